trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Trap sequencer for the commit stage. It watches the committing
//   instruction's synchronous exception flags and the enabled machine
//   interrupts. It accepts at most one trap per IDLE period. For each trap it:
//     - issues a one-cycle strobe to the CSR file,
//     - records the cause and the PC for mepc,
//     - holds a pipeline flush for 1 + FLUSH_CYCLES cycles.
//
// Parameters
//   FLUSH_CYCLES      : number of flush cycles after the trap strobe (1..7)
//
// Ports
//   clk               : rising-edge clock
//   nrst              : asynchronous active-low reset
//   stall             : pipeline stall; no trap is accepted while high
//   commit_valid      : an instruction is at the commit point this cycle
//   commit_pc         : PC of the committing instruction
//   exc_*             : synchronous exception flags of that instruction
//   cur_mode          : privilege mode (0 U, 1 S, 3 M)
//   ext_irq           : asynchronous external interrupt level
//   timer_irq         : synchronous machine-timer interrupt level
//   m_eie, m_tie      : interrupt enables, already gated by mstatus.MIE
//   exception_pending : one-cycle trap strobe (TRAP state)
//   m_cause           : {interrupt bit, 31-bit cause code}
//   pc_exc            : PC written to mepc
//   asy_int           : the recorded trap is an interrupt
//   flush             : kill younger instructions (TRAP and FLUSH states)
// -----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        stall,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        exc_i_misaligned,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_ecall,
    input  logic        exc_l_misaligned,
    input  logic        exc_s_misaligned,
    input  logic [1:0]  cur_mode,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        m_eie,
    input  logic        m_tie,
    output logic        exception_pending,
    output logic [31:0] m_cause,
    output logic [31:0] pc_exc,
    output logic        asy_int,
    output logic        flush
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter value seen in the last FLUSH cycle.
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    localparam logic [30:0] CODE_EXT_IRQ   = 31'd11;
    localparam logic [30:0] CODE_TIMER_IRQ = 31'd7;

    // Cause code of the highest-priority synchronous exception.
    // The ECALL code depends on the mode it was issued from. The reserved
    // mode 2 is treated like M.
    function automatic logic [30:0] exc_code(
        input logic       i_mis,
        input logic       illegal,
        input logic       ebreak,
        input logic       ecall,
        input logic       l_mis,
        input logic       s_mis,
        input logic [1:0] mode
    );
        logic [30:0] code;
        if (i_mis) begin
            code = 31'd0;
        end else if (illegal) begin
            code = 31'd2;
        end else if (ebreak) begin
            code = 31'd3;
        end else if (ecall) begin
            case (mode)
                2'd0:    code = 31'd8;
                2'd1:    code = 31'd9;
                default: code = 31'd11;
            endcase
        end else if (l_mis) begin
            code = 31'd4;
        end else if (s_mis) begin
            code = 31'd6;
        end else begin
            code = 31'd0;
        end
        return code;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ext_meta_q, ext_meta_d;
    logic        ext_sync_q, ext_sync_d;
    logic        exception_pending_q, exception_pending_d;
    logic        flush_q, flush_d;
    logic        asy_int_q, asy_int_d;
    logic [31:0] m_cause_q, m_cause_d;
    logic [31:0] pc_exc_q, pc_exc_d;

    logic        take_s;
    logic        ext_req_s;
    logic        irq_req_s;
    logic        exc_req_s;

    assign take_s    = commit_valid & ~stall & (state_q == IDLE);
    assign ext_req_s = ext_sync_q & m_eie;
    assign irq_req_s = ext_req_s | (timer_irq & m_tie);
    assign exc_req_s = exc_i_misaligned | exc_illegal | exc_ebreak |
                       exc_ecall | exc_l_misaligned | exc_s_misaligned;

    // Next-state, cause/PC capture, flush counter and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ext_meta_d = ext_irq;
        ext_sync_d = ext_meta_q;
        asy_int_d  = asy_int_q;
        m_cause_d  = m_cause_q;
        pc_exc_d   = pc_exc_q;

        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (take_s && (irq_req_s || exc_req_s)) begin
                    state_d  = TRAP;
                    pc_exc_d = commit_pc;
                    // Interrupts win over any exception on the same instruction.
                    if (irq_req_s) begin
                        asy_int_d = 1'b1;
                        m_cause_d = {1'b1, (ext_req_s ? CODE_EXT_IRQ : CODE_TIMER_IRQ)};
                    end else begin
                        asy_int_d = 1'b0;
                        m_cause_d = {1'b0, exc_code(exc_i_misaligned, exc_illegal,
                                                    exc_ebreak, exc_ecall,
                                                    exc_l_misaligned, exc_s_misaligned,
                                                    cur_mode)};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            TRAP: begin
                // The strobe lasts one cycle and does not wait for stall.
                state_d = FLUSH;
                cnt_d   = 3'd0;
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = FLUSH;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        // Strobe and flush are decoded from the next state so that they
        // come straight from flops.
        exception_pending_d = (state_d == TRAP);
        flush_d             = (state_d == TRAP) || (state_d == FLUSH);
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q             <= IDLE;
            cnt_q               <= 3'd0;
            ext_meta_q          <= 1'b0;
            ext_sync_q          <= 1'b0;
            exception_pending_q <= 1'b0;
            flush_q             <= 1'b0;
            asy_int_q           <= 1'b0;
            m_cause_q           <= 32'd0;
            pc_exc_q            <= 32'd0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            ext_meta_q          <= ext_meta_d;
            ext_sync_q          <= ext_sync_d;
            exception_pending_q <= exception_pending_d;
            flush_q             <= flush_d;
            asy_int_q           <= asy_int_d;
            m_cause_q           <= m_cause_d;
            pc_exc_q            <= pc_exc_d;
        end
    end

    assign exception_pending = exception_pending_q;
    assign flush             = flush_q;
    assign asy_int           = asy_int_q;
    assign m_cause           = m_cause_q;
    assign pc_exc            = pc_exc_q;

endmodule
